// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, instruction classes,
// opcode/funct constants and datapath select codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StExecI   = 4'd3,
    StMemAddr = 4'd4,
    StMemRd   = 4'd5,
    StMemWr   = 4'd6,
    StWbR     = 4'd7,
    StWbI     = 4'd8,
    StWbMem   = 4'd9,
    StBranch  = 4'd10,
    StJump    = 4'd11,
    StJal     = 4'd12,
    StJr      = 4'd13,
    StTrap    = 4'd14
  } mcState;

  typedef enum logic [3:0] {
    ClsR       = 4'd0,
    ClsI       = 4'd1,
    ClsLoad    = 4'd2,
    ClsStore   = 4'd3,
    ClsBranch  = 4'd4,
    ClsJ       = 4'd5,
    ClsJal     = 4'd6,
    ClsJr      = 4'd7,
    ClsNop     = 4'd8,
    ClsIllegal = 4'd9
  } instrClass;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2A;
  localparam logic [5:0] FnSltu = 6'h2B;

  localparam logic [3:0] AluAnd  = 4'd0;
  localparam logic [3:0] AluOr   = 4'd1;
  localparam logic [3:0] AluAdd  = 4'd2;
  localparam logic [3:0] AluNor  = 4'd3;
  localparam logic [3:0] AluXor  = 4'd4;
  localparam logic [3:0] AluSub  = 4'd6;
  localparam logic [3:0] AluSlt  = 4'd7;
  localparam logic [3:0] AluSll  = 4'd10;
  localparam logic [3:0] AluSltu = 4'd14;

  localparam logic [1:0] PcSrcAlu    = 2'd0;
  localparam logic [1:0] PcSrcAluOut = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;
  localparam logic [1:0] PcSrcRs     = 2'd3;

  localparam logic [1:0] ASelRs = 2'd0;
  localparam logic [1:0] ASelRt = 2'd1;
  localparam logic [1:0] ASelPc = 2'd2;

  localparam logic [2:0] BSelRt     = 3'd0;
  localparam logic [2:0] BSelImm    = 3'd1;
  localparam logic [2:0] BSelZero   = 3'd2;
  localparam logic [2:0] BSelFour   = 3'd3;
  localparam logic [2:0] BSelShamt  = 3'd4;
  localparam logic [2:0] BSelImmSh2 = 3'd5;

  localparam logic [1:0] RegDstRt = 2'd0;
  localparam logic [1:0] RegDstRd = 2'd1;
  localparam logic [1:0] RegDstRa = 2'd2;

  localparam logic [1:0] RegDataAluOut = 2'd0;
  localparam logic [1:0] RegDataPc     = 2'd1;
  localparam logic [1:0] RegDataMdr    = 2'd2;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps the IR contents to an instruction class,
// the ALU operation for the execute step and the immediate extension mode.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [31:0] instruction,
  output instrClass   iClass,
  output logic [3:0]  aluControl,
  output logic        extendSign
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];

  always_comb begin
    iClass     = ClsIllegal;
    aluControl = AluAdd;
    extendSign = 1'b0;
    // An all-zero word would otherwise decode as SLL $0,$0,0.
    if (instruction == 32'd0) begin
      iClass = ClsNop;
    end else begin
      case (opcode)
        OpRtype: begin
          iClass = ClsR;
          case (funct)
            FnAdd, FnAddu: aluControl = AluAdd;
            FnSub, FnSubu: aluControl = AluSub;
            FnAnd:         aluControl = AluAnd;
            FnOr:          aluControl = AluOr;
            FnXor:         aluControl = AluXor;
            FnNor:         aluControl = AluNor;
            FnSlt:         aluControl = AluSlt;
            FnSltu:        aluControl = AluSltu;
            FnSll:         aluControl = AluSll;
            FnJr:          iClass = ClsJr;
            default:       iClass = ClsIllegal;
          endcase
        end
        OpAddi: begin
          iClass     = ClsI;
          aluControl = AluAdd;
          extendSign = 1'b1;
        end
        OpAddiu: begin
          iClass     = ClsI;
          aluControl = AluAdd;
        end
        OpSlti: begin
          iClass     = ClsI;
          aluControl = AluSlt;
          extendSign = 1'b1;
        end
        OpAndi: begin
          iClass     = ClsI;
          aluControl = AluAnd;
        end
        OpOri: begin
          iClass     = ClsI;
          aluControl = AluOr;
        end
        OpXori: begin
          iClass     = ClsI;
          aluControl = AluXor;
        end
        OpLw: begin
          iClass     = ClsLoad;
          extendSign = 1'b1;
        end
        OpSw: begin
          iClass     = ClsStore;
          extendSign = 1'b1;
        end
        OpBeq, OpBne: begin
          iClass     = ClsBranch;
          aluControl = AluSub;
          extendSign = 1'b1;
        end
        OpJ:     iClass = ClsJ;
        OpJal:   iClass = ClsJal;
        default: iClass = ClsIllegal;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM for the MIPS datapath with a shared variable-latency memory.
// State is registered; datapath controls are decoded from state, Instruction and MemReady.
module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instruction,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        IRWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [1:0]  ALUASel,
  output logic [2:0]  ALUBSel,
  output logic [3:0]  ALUControl,
  output logic        ExtendSign,
  output logic [1:0]  RegDst,
  output logic [1:0]  RegDataSel,
  output logic        RegWrite,
  output logic        IllegalOp,
  output logic [3:0]  State
);

  mcState     stateQ;
  logic       illegalQ;
  instrClass  decClass;
  logic [3:0] decAlu;
  logic       decExt;
  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = Instruction[31:26];
  assign funct  = Instruction[5:0];

  mc_decode uDecode (
    .instruction (Instruction),
    .iClass      (decClass),
    .aluControl  (decAlu),
    .extendSign  (decExt)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateQ   <= StFetch;
      illegalQ <= 1'b0;
    end else begin
      case (stateQ)
        StFetch:   if (MemReady) stateQ <= StDecode;
        StDecode: begin
          case (decClass)
            ClsNop:             stateQ <= StFetch;
            ClsR:               stateQ <= StExecR;
            ClsJr:              stateQ <= StJr;
            ClsI:               stateQ <= StExecI;
            ClsLoad, ClsStore:  stateQ <= StMemAddr;
            ClsBranch:          stateQ <= StBranch;
            ClsJ:               stateQ <= StJump;
            ClsJal:             stateQ <= StJal;
            default: begin
              stateQ   <= StTrap;
              illegalQ <= 1'b1;
            end
          endcase
        end
        StExecR:   stateQ <= StWbR;
        StExecI:   stateQ <= StWbI;
        StMemAddr: stateQ <= (opcode == OpSw) ? StMemWr : StMemRd;
        StMemRd:   if (MemReady) stateQ <= StWbMem;
        StMemWr:   if (MemReady) stateQ <= StFetch;
        StWbR, StWbI, StWbMem, StBranch, StJump, StJal, StJr: stateQ <= StFetch;
        StTrap:    stateQ <= StTrap;
        default:   stateQ <= StFetch;
      endcase
    end
  end

  assign State     = stateQ;
  assign IllegalOp = illegalQ;

  // Reset overrides the state decode so an in-flight access is abandoned immediately.
  always_comb begin
    PCWrite    = 1'b0;
    PCSrc      = PcSrcAlu;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    ALUASel    = ASelRs;
    ALUBSel    = BSelRt;
    ALUControl = AluAnd;
    ExtendSign = 1'b0;
    RegDst     = RegDstRt;
    RegDataSel = RegDataAluOut;
    RegWrite   = 1'b0;
    if (!Reset) begin
      case (stateQ)
        StFetch: begin
          MemRead    = 1'b1;
          ALUASel    = ASelPc;
          ALUBSel    = BSelFour;
          ALUControl = AluAdd;
          IRWrite    = MemReady;
          PCWrite    = MemReady;
          PCSrc      = PcSrcAlu;
        end
        StDecode: begin
          ALUASel    = ASelPc;
          ALUBSel    = BSelImmSh2;
          ExtendSign = 1'b1;
          ALUControl = AluAdd;
        end
        StExecR: begin
          ALUControl = decAlu;
          if (funct == FnSll) begin
            ALUASel = ASelRt;
            ALUBSel = BSelShamt;
          end else begin
            ALUASel = ASelRs;
            ALUBSel = BSelRt;
          end
        end
        StExecI: begin
          ALUASel    = ASelRs;
          ALUBSel    = BSelImm;
          ExtendSign = decExt;
          ALUControl = decAlu;
        end
        StMemAddr: begin
          ALUASel    = ASelRs;
          ALUBSel    = BSelImm;
          ExtendSign = 1'b1;
          ALUControl = AluAdd;
        end
        StMemRd: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        StMemWr: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        StWbR: begin
          RegDst     = RegDstRd;
          RegDataSel = RegDataAluOut;
          RegWrite   = 1'b1;
        end
        StWbI: begin
          RegDst     = RegDstRt;
          RegDataSel = RegDataAluOut;
          RegWrite   = 1'b1;
        end
        StWbMem: begin
          RegDst     = RegDstRt;
          RegDataSel = RegDataMdr;
          RegWrite   = 1'b1;
        end
        StBranch: begin
          ALUASel    = ASelRs;
          ALUBSel    = BSelRt;
          ALUControl = AluSub;
          PCSrc      = PcSrcAluOut;
          PCWrite    = (opcode == OpBne) ? ~Zero : Zero;
        end
        StJump: begin
          PCWrite = 1'b1;
          PCSrc   = PcSrcJump;
        end
        StJal: begin
          PCWrite    = 1'b1;
          PCSrc      = PcSrcJump;
          RegDst     = RegDstRa;
          RegDataSel = RegDataPc;
          RegWrite   = 1'b1;
        end
        StJr: begin
          PCWrite = 1'b1;
          PCSrc   = PcSrcRs;
        end
        default: ;
      endcase
    end
  end

endmodule
